// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        WRITE = 2'd3
    } md_state_t;

    typedef enum logic {
        MULT = 1'b0,
        DIV  = 1'b1
    } md_sel_t;

    localparam int MD_CYCLES_DEF = 32;
    localparam int CNT_W_DEF     = 6;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Control-unit side of the multiply/divide sequencer: requests, MTHI/MTLO writes, Hi/Lo and status.
interface muldiv_ctrl_if;
    logic        op_mult;
    logic        op_div;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output op_mult, op_div, rs_val, rt_val, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  op_mult, op_div, rs_val, rt_val, hi_we, lo_we, wdata,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/hilo_regs.sv
// Architectural Hi/Lo registers: result capture has priority over MTHI/MTLO writes.
module hilo_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_en,
    input  logic [31:0] cap_hi,
    input  logic [31:0] cap_lo,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    logic [1:0][31:0] cap_val;
    logic [1:0]       we;

    // Index 0 is Lo, index 1 is Hi.
    assign cap_val = {cap_hi, cap_lo};
    assign we      = {hi_we, lo_we};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_reg
            logic [31:0] val_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    val_reg <= '0;
                end else if (cap_en) begin
                    val_reg <= cap_val[gi];
                end else if (we[gi]) begin
                    val_reg <= wdata;
                end
            end
        end
    endgenerate

    assign lo = g_reg[0].val_reg;
    assign hi = g_reg[1].val_reg;

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiply/divide datapath: latches operands, pulses the unit start,
// counts iterations, captures Hi/Lo and stalls the control unit while busy.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave cu,
    output logic [31:0]  opa,
    output logic [31:0]  opb,
    output logic         mult_start,
    output logic         div_start,
    input  logic [31:0]  mult_hi,
    input  logic [31:0]  mult_lo,
    input  logic [31:0]  div_hi,
    input  logic [31:0]  div_lo
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        state_reg;
    md_sel_t          sel_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      opa_reg;
    logic [31:0]      opb_reg;
    logic             mult_start_reg;
    logic             div_start_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             div_zero_reg;

    logic             cap_en;
    logic [31:0]      cap_hi;
    logic [31:0]      cap_lo;
    logic             hilo_hi_we;
    logic             hilo_lo_we;
    logic [31:0]      hi_w;
    logic [31:0]      lo_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            sel_reg        <= MULT;
            cnt_reg        <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            mult_start_reg <= 1'b0;
            div_start_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            div_zero_reg   <= 1'b0;
        end else begin
            mult_start_reg <= 1'b0;
            div_start_reg  <= 1'b0;
            done_reg       <= 1'b0;
            div_zero_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cu.op_mult) begin
                        opa_reg        <= cu.rs_val;
                        opb_reg        <= cu.rt_val;
                        sel_reg        <= MULT;
                        mult_start_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= START;
                    end else if (cu.op_div && (cu.rt_val != 32'd0)) begin
                        opa_reg       <= cu.rs_val;
                        opb_reg       <= cu.rt_val;
                        sel_reg       <= DIV;
                        div_start_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= START;
                    end else if (cu.op_div) begin
                        // Divide by zero never starts the divider; Hi/Lo keep their values.
                        div_zero_reg <= 1'b1;
                    end
                end
                START: begin
                    cnt_reg   <= CNT_LOAD;
                    state_reg <= RUN;
                end
                RUN: begin
                    if (cnt_reg == CNT_ONE) begin
                        cnt_reg   <= '0;
                        state_reg <= WRITE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                WRITE: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cap_en     = (state_reg == WRITE);
    assign cap_hi     = (sel_reg == MULT) ? mult_hi : div_hi;
    assign cap_lo     = (sel_reg == MULT) ? mult_lo : div_lo;
    assign hilo_hi_we = cu.hi_we && (state_reg == IDLE);
    assign hilo_lo_we = cu.lo_we && (state_reg == IDLE);

    hilo_regs u_hilo (
        .clk    (clk),
        .reset  (reset),
        .cap_en (cap_en),
        .cap_hi (cap_hi),
        .cap_lo (cap_lo),
        .hi_we  (hilo_hi_we),
        .lo_we  (hilo_lo_we),
        .wdata  (cu.wdata),
        .hi     (hi_w),
        .lo     (lo_w)
    );

    assign opa         = opa_reg;
    assign opb         = opb_reg;
    assign mult_start  = mult_start_reg;
    assign div_start   = div_start_reg;
    assign cu.hi       = hi_w;
    assign cu.lo       = lo_w;
    assign cu.busy     = busy_reg;
    assign cu.done     = done_reg;
    assign cu.div_zero = div_zero_reg;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the shared multi-cycle multiply/divide datapath in the processor.
- Accepts MULT/DIV requests from the control unit and latches the operands.
- Pulses the start (local reset) input of the Booth multiplier or the divider, counts iteration cycles and captures the results into architectural Hi/Lo registers.
- Drives a stall (busy) to the control unit, handles MTHI/MTLO writes, and flags divide-by-zero without starting the divider.

Parameters:
MD_CYCLES, 32, iteration edges the selected unit needs after its start cycle before results are valid
CNT_W, 6, counter width; must hold MD_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
op_mult  in  1  request signed multiply (level, sampled in IDLE)
op_div  in  1  request signed divide
rs_val  in  32  operand A / dividend
rt_val  in  32  operand B / divisor
hi_we  in  1  MTHI write
lo_we  in  1  MTLO write
wdata  in  32  MTHI/MTLO data
opa  out  32  latched operand A to units
opb  out  32  latched operand B to units
mult_start  out  1  multiplier local-reset/load pulse
div_start  out  1  divider local-reset/load pulse
mult_hi, mult_lo  in  32 each  multiplier results
div_hi, div_lo  in  32 each  remainder, quotient
hi, lo  out  32 each  architectural Hi/Lo
busy  out  1  stall request to control unit
done  out  1  one-cycle completion pulse
div_zero  out  1  one-cycle divide-by-zero pulse

Behaviour:
Reset:
- state=IDLE; hi, lo, opa, opb, counter all 0; busy, done, div_zero, mult_start, div_start all 0.
- Reset mid-operation aborts immediately, with no Hi/Lo capture and no done.

States and transitions:
- IDLE → START on an accepted op.
- START → RUN after exactly 1 cycle.
- RUN → WRITE after MD_CYCLES cycles.
- WRITE → IDLE after 1 cycle.

IDLE:
- op_mult=1: latch opa=rs_val, opb=rt_val, sel=MULT, go to START.
- Else op_div=1 and rt_val≠0: same, with sel=DIV.
- op_mult has priority when both are high; op_div is dropped.
- op_div=1 with rt_val=0: stay in IDLE, pulse div_zero for the next cycle, leave hi/lo unchanged, never raise busy.

START:
- Assert exactly one start line for one cycle (mult_start for MULT, div_start for DIV).
- Load counter=MD_CYCLES.

RUN:
- Both start lines low; decrement counter each cycle.
- Leave RUN when the counter reaches 1, i.e. after MD_CYCLES RUN cycles.

WRITE:
- Unit outputs are valid in this cycle.
- At the end of the cycle, capture hi/lo from the selected unit: MULT→mult_hi/mult_lo; DIV→div_hi/div_lo.

done:
- Registered; high during the first IDLE cycle after WRITE.
- This is the first cycle in which the new hi/lo are visible.

busy:
- busy = (state≠IDLE). High from START through WRITE inclusive.

Latency:
- Request sampled at edge k. START is cycle k+1. RUN is cycles k+2..k+33. WRITE is cycle k+34. done and new hi/lo appear in cycle k+35.
- A new request may be accepted in that same cycle (k+35).

Requests while busy:
- op_mult, op_div, hi_we and lo_we are all ignored. The control unit must hold the request or stall.

MTHI/MTLO:
- Applied only in IDLE, at the sampling edge.
- Simultaneous with op acceptance: the write is applied and the later capture overwrites it.

Operand stability:
- opa/opb are held stable from START until the next acceptance.

Width rules:
- No arithmetic is performed in this block.
- The counter never wraps; it saturates at 0 outside RUN.

Decomposition:
- muldiv_pkg holds:
  - the state enum (IDLE, START, RUN, WRITE);
  - the op-select enum (MULT, DIV);
  - the MD_CYCLES default.
- One natural sub-module: hilo_regs (Hi/Lo storage with capture and MTHI/MTLO write ports).
- Counter and FSM stay in muldiv_ctrl.

Test Plan:
1. Multiply, with the real multiplier attached:
   - Stimulus: rs_val=7, rt_val=0xFFFFFFFD, op_mult sampled at edge k.
   - Required: mult_start high only in cycle k+1; busy high k+1..k+34; done and hi=0xFFFFFFFF, lo=0xFFFFFFEB in cycle k+35.
2. Divide, with a behavioural divider model of MD_CYCLES latency:
   - Stimulus: rs_val=100, rt_val=7, op_div.
   - Required: div_start single pulse; hi=2, lo=14 at k+35; mult_start never high.
3. Divide by zero:
   - Stimulus: op_div with rt_val=0, after hi=0x1234 was set via MTHI.
   - Required: div_zero pulse at k+1; busy stays 0; hi=0x1234 unchanged; no done.
4. Reset mid-operation:
   - Stimulus: op_mult, then reset asserted in RUN cycle 10 for 1 cycle.
   - Required: next cycle state IDLE, hi=lo=0, busy=0; no done ever pulses.
5. Simultaneous requests and busy masking:
   - Stimulus: op_mult and op_div both high → only mult_start pulses. During busy, hi_we=1 with wdata=0xAAAA and op_div=1.
   - Required: both ignored; hi equals the multiply result at done.
6. Back-to-back operations:
   - Stimulus: op_mult held high continuously.
   - Required: second acceptance in the done cycle (k+35); second mult_start at k+36; done pulses exactly 35 cycles apart.
